// File: rtl/blink_seq_ctrl.sv
// LED pattern sequencer: four-entry pattern/duration table stepped on a
// prescaled timebase, with one-shot or looping playback.
module blink_seq_ctrl #(
    parameter int PRESCALE = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  last_step,
    input  logic        loop,
    output logic [7:0]  led,
    output logic        busy,
    output logic        done,
    output logic [1:0]  step
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    logic [15:0] pat_tab [4];
    logic [PW-1:0] pre;
    logic [7:0]  dur;
    logic [1:0]  last_q;
    logic        loop_q;
    logic        tick;
    logic [1:0]  step_nxt;

    assign tick     = (state == RUN) && (pre == PMAX);
    assign step_nxt = step + 2'd1;

    // Loads below read the pre-edge table, so a same-edge write lands next time.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) pat_tab[i] <= '0;
        end else if (wr_en) begin
            pat_tab[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            led    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            step   <= '0;
            pre    <= '0;
            dur    <= '0;
            last_q <= '0;
            loop_q <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    pre <= '0;
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        step   <= '0;
                        led    <= pat_tab[0][15:8];
                        dur    <= pat_tab[0][7:0];
                        last_q <= last_step;
                        loop_q <= loop;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        led   <= '0;
                        busy  <= 1'b0;
                        step  <= '0;
                        pre   <= '0;
                    end else begin
                        pre <= tick ? '0 : pre + 1'b1;
                        if (tick) begin
                            if (dur != 8'd0) begin
                                dur <= dur - 8'd1;
                            end else if (step != last_q) begin
                                step <= step_nxt;
                                led  <= pat_tab[step_nxt][15:8];
                                dur  <= pat_tab[step_nxt][7:0];
                            end else if (loop_q) begin
                                step <= '0;
                                led  <= pat_tab[0][15:8];
                                dur  <= pat_tab[0][7:0];
                            end else begin
                                state <= IDLE;
                                led   <= '0;
                                busy  <= 1'b0;
                                step  <= '0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blink_seq_ctrl.sv
// Directed bench for blink_seq_ctrl at PRESCALE=4.
// Checks playback timing, looping, stop, table writes and reset.
module tb_blink_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        stop;
    logic [1:0]  last_step;
    logic        loop;
    logic [7:0]  led;
    logic        busy;
    logic        done;
    logic [1:0]  step;

    int total;
    int bad;

    blink_seq_ctrl #(.PRESCALE(4)) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start(start),
        .stop(stop),
        .last_step(last_step),
        .loop(loop),
        .led(led),
        .busy(busy),
        .done(done),
        .step(step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".led"}, {24'd0, led}, 32'd0);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".step"}, {30'd0, step}, 32'd0);
    endtask

    task automatic expect_run(input int n, input logic [7:0] l,
                              input logic [1:0] s);
        for (int i = 0; i < n; i++) begin
            chk("run.led", {24'd0, led}, {24'd0, l});
            chk("run.step", {30'd0, step}, {30'd0, s});
            chk("run.busy", {31'd0, busy}, 32'd1);
            chk("run.done", {31'd0, done}, 32'd0);
            cyc();
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [1:0] ls, input logic lp);
        start = 1'b1;
        last_step = ls;
        loop = lp;
        cyc();
        start = 1'b0;
    endtask

    task automatic done_chk(input string tag);
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        idle_chk(tag);
        cyc();
        chk({tag, ".done_end"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start = 1'b0;
        stop = 1'b0;
        last_step = '0;
        loop = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        idle_chk("reset");
        chk("reset.done", {31'd0, done}, 32'd0);

        wr(2'd0, 16'h0101);
        wr(2'd1, 16'h0200);
        wr(2'd2, 16'h0400);

        // one-shot
        go(2'd2, 1'b0);
        expect_run(8, 8'h01, 2'd0);
        expect_run(4, 8'h02, 2'd1);
        expect_run(4, 8'h04, 2'd2);
        done_chk("oneshot");

        // looping, then stop mid-step
        go(2'd2, 1'b1);
        for (int p = 0; p < 2; p++) begin
            expect_run(8, 8'h01, 2'd0);
            expect_run(4, 8'h02, 2'd1);
            expect_run(4, 8'h04, 2'd2);
        end
        expect_run(3, 8'h01, 2'd0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        idle_chk("stop");
        chk("stop.done", {31'd0, done}, 32'd0);
        cyc();
        chk("stop.done2", {31'd0, done}, 32'd0);

        // start while busy is ignored
        go(2'd2, 1'b0);
        expect_run(3, 8'h01, 2'd0);
        start = 1'b1;
        expect_run(1, 8'h01, 2'd0);
        start = 1'b0;
        expect_run(4, 8'h01, 2'd0);
        expect_run(4, 8'h02, 2'd1);
        expect_run(4, 8'h04, 2'd2);
        done_chk("restart");

        // stop while idle is ignored
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        idle_chk("idlestop");
        chk("idlestop.done", {31'd0, done}, 32'd0);

        // writes during run
        go(2'd2, 1'b1);
        expect_run(2, 8'h01, 2'd0);
        wr_en = 1'b1;
        wr_addr = 2'd1;
        wr_data = 16'hAA00;
        expect_run(1, 8'h01, 2'd0);
        wr_en = 1'b0;
        expect_run(5, 8'h01, 2'd0);
        expect_run(4, 8'hAA, 2'd1);
        expect_run(3, 8'h04, 2'd2);
        wr_en = 1'b1;
        wr_addr = 2'd0;
        wr_data = 16'h5500;
        expect_run(1, 8'h04, 2'd2);
        wr_en = 1'b0;
        expect_run(8, 8'h01, 2'd0);
        expect_run(4, 8'hAA, 2'd1);
        expect_run(4, 8'h04, 2'd2);
        expect_run(4, 8'h55, 2'd0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        idle_chk("wrstop");

        // reset mid-run clears table
        go(2'd2, 1'b0);
        expect_run(4, 8'h55, 2'd0);
        expect_run(2, 8'hAA, 2'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        idle_chk("midreset");
        chk("midreset.done", {31'd0, done}, 32'd0);
        go(2'd0, 1'b0);
        expect_run(4, 8'h00, 2'd0);
        done_chk("cleared");

        // reset dominates start and write
        reset = 1'b1;
        start = 1'b1;
        wr_en = 1'b1;
        wr_addr = 2'd0;
        wr_data = 16'hFFFF;
        cyc();
        reset = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
        idle_chk("rstdom");
        go(2'd0, 1'b0);
        expect_run(4, 8'h00, 2'd0);
        done_chk("rstdom");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
